// File: rtl/booth_prod_accumulator.sv
// Signed saturating accumulator for the Booth multiplier product stream.
// Sums a programmed number of products and holds the result on a valid/ready port.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | waiting for start; len sampled with it
//   S_ACCUM | accepting one product per cycle, count runs down to 1
//   S_HOLD  | result presented on acc port until acc_ready
module booth_prod_accumulator #(
  parameter int PW    = 8,
  parameter int AW    = 16,
  parameter int LEN_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_prod_valid,
  output logic                 o_prod_ready,
  input  logic signed [PW-1:0] i_prod,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ready,
  output logic signed [AW-1:0] o_acc_out,
  output logic                 o_sat_flag,
  output logic                 o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic signed [AW-1:0]  r_acc;
  logic [LEN_W-1:0]      r_count;
  logic                  r_sat;

  logic                  w_take_start;
  logic                  w_xfer;
  logic                  w_last;
  logic signed [AW:0]    w_prod_ext;
  logic signed [AW:0]    w_sum;
  logic                  w_ovf_pos;
  logic                  w_ovf_neg;
  logic signed [AW-1:0]  w_acc_nxt;

  assign w_take_start = i_start && (r_state == S_IDLE);
  assign w_xfer       = i_prod_valid && (r_state == S_ACCUM);
  assign w_last       = (r_count == LEN_W'(1));

  // One guard bit above AW exposes overflow in either direction.
  assign w_prod_ext = {{(AW+1-PW){i_prod[PW-1]}}, i_prod};
  assign w_sum      = {r_acc[AW-1], r_acc} + w_prod_ext;
  assign w_ovf_pos  = ~w_sum[AW] &  w_sum[AW-1];
  assign w_ovf_neg  =  w_sum[AW] & ~w_sum[AW-1];

  always_comb begin
    w_acc_nxt = w_sum[AW-1:0];
    if (w_ovf_pos)      w_acc_nxt = ACC_MAX;
    else if (w_ovf_neg) w_acc_nxt = ACC_MIN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_len == '0) ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_xfer && w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_acc_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_take_start) begin
      r_acc   <= '0;
      r_count <= i_len;
      r_sat   <= 1'b0;
    end else if (w_xfer) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count - LEN_W'(1);
      if (w_ovf_pos || w_ovf_neg) r_sat <= 1'b1;
    end
  end

  assign o_prod_ready = (r_state == S_ACCUM);
  assign o_acc_valid  = (r_state == S_HOLD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_acc_out    = r_acc;
  assign o_sat_flag   = r_sat;

endmodule

// File: tb/tb_booth_prod_accumulator.sv
// Randomized and directed checks of booth_prod_accumulator against a plain
// integer model of a saturating running sum.
module tb_booth_prod_accumulator;

  localparam int PW    = 8;
  localparam int AW    = 12;
  localparam int LEN_W = 8;
  localparam int AMAX  = (1 << (AW-1)) - 1;
  localparam int AMIN  = -(1 << (AW-1));

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [LEN_W-1:0]     i_len = '0;
  logic                 i_prod_valid = 1'b0;
  logic                 o_prod_ready;
  logic signed [PW-1:0] i_prod = '0;
  logic                 o_acc_valid;
  logic                 i_acc_ready = 1'b0;
  logic signed [AW-1:0] o_acc_out;
  logic                 o_sat_flag;
  logic                 o_busy;

  int n_vec = 0;
  int n_bad = 0;
  int q_prod[$];

  booth_prod_accumulator #(.PW(PW), .AW(AW), .LEN_W(LEN_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_prod_valid (i_prod_valid),
    .o_prod_ready (o_prod_ready),
    .i_prod       (i_prod),
    .o_acc_valid  (o_acc_valid),
    .i_acc_ready  (i_acc_ready),
    .o_acc_out    (o_acc_out),
    .o_sat_flag   (o_sat_flag),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int n, output int acc, output bit sat);
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += q_prod[i];
      if (acc > AMAX) begin
        acc = AMAX;
        sat = 1'b1;
      end else if (acc < AMIN) begin
        acc = AMIN;
        sat = 1'b1;
      end
    end
  endfunction

  // Entered and left at 1ns after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input int len, input int gap_pct,
                        input int bp, input bit poke, input bit start_on_ack);
    int  idx;
    int  budget;
    int  exp_acc;
    bit  exp_sat;
    bit  xfer;
    longint held;
    idx = 0;
    model(len, exp_acc, exp_sat);
    i_prod_valid = 1'b0;
    i_start = 1'b1;
    i_len   = LEN_W'(len);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_len   = LEN_W'($urandom);
    chk({tag, ":busy"}, longint'(o_busy), 1);
    chk({tag, ":sat_clr"}, longint'(o_sat_flag), 0);
    budget = len * 8 + 50;
    while (idx < len && budget > 0) begin
      i_prod_valid = ($urandom_range(0, 99) >= gap_pct);
      i_prod = i_prod_valid ? PW'(q_prod[idx]) : PW'($urandom);
      if (poke) begin
        i_start = ($urandom_range(0, 3) == 0);
        i_len   = LEN_W'(7);
      end
      xfer = i_prod_valid && o_prod_ready;
      @(posedge i_clk); #1;
      if (xfer) idx++;
      budget--;
    end
    i_prod_valid = 1'b0;
    i_start = 1'b0;
    if (idx < len) chk({tag, ":timeout"}, idx, len);
    chk({tag, ":valid"}, longint'(o_acc_valid), 1);
    chk({tag, ":acc"}, longint'(o_acc_out), exp_acc);
    chk({tag, ":sat"}, longint'(o_sat_flag), exp_sat);
    held = longint'(o_acc_out);
    for (int k = 0; k < bp; k++) begin
      i_acc_ready = 1'b0;
      i_start = poke && ($urandom_range(0, 1) == 1);
      i_len   = LEN_W'(7);
      @(posedge i_clk); #1;
      chk({tag, ":bp_valid"}, longint'(o_acc_valid), 1);
      chk({tag, ":bp_acc"}, longint'(o_acc_out), held);
    end
    i_acc_ready = 1'b1;
    i_start = start_on_ack;
    i_len   = LEN_W'(7);
    @(posedge i_clk); #1;
    i_acc_ready = 1'b0;
    i_start = 1'b0;
    chk({tag, ":drop"}, longint'(o_acc_valid), 0);
    chk({tag, ":idle"}, longint'(o_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int len;
    repeat (3) @(posedge i_clk);
    chk("rst_valid", longint'(o_acc_valid), 0);
    chk("rst_ready", longint'(o_prod_ready), 0);
    chk("rst_acc", longint'(o_acc_out), 0);
    chk("rst_busy", longint'(o_busy), 0);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Reset in the middle of an accumulation.
    i_start = 1'b1; i_len = LEN_W'(4);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_prod_valid = 1'b1; i_prod = 8'sd50;
    repeat (2) begin @(posedge i_clk); #1; end
    i_prod_valid = 1'b0;
    chk("mid_acc", longint'(o_acc_out), 100);
    i_rst_n = 1'b0; #2;
    chk("mrst_acc", longint'(o_acc_out), 0);
    chk("mrst_busy", longint'(o_busy), 0);
    chk("mrst_ready", longint'(o_prod_ready), 0);
    chk("mrst_valid", longint'(o_acc_valid), 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_valid", longint'(o_acc_valid), 0);
    q_prod = '{5};
    run_op("after_rst", 1, 0, 0, 0, 0);

    q_prod = '{15, -9, 21};
    run_op("dot3", 3, 0, 0, 0, 0);

    q_prod = '{64, -56, 8, -42};
    run_op("bubbles", 4, 50, 5, 0, 0);

    q_prod.delete();
    repeat (40) q_prod.push_back(64);
    run_op("sat_pos", 40, 0, 0, 0, 0);
    q_prod.delete();
    repeat (40) q_prod.push_back(-56);
    run_op("sat_neg", 40, 0, 0, 0, 0);

    q_prod.delete();
    run_op("len0", 0, 0, 2, 1, 0);

    i_prod_valid = 1'b1; i_prod = 8'sd99;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("idle_noready", longint'(o_prod_ready), 0);
    end
    i_prod_valid = 1'b0;
    q_prod = '{10, 20, 30, -5, 1, 2, 3};
    run_op("pokes", 7, 20, 3, 1, 1);

    q_prod = '{3, 4};
    run_op("b2b", 2, 0, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      q_prod.delete();
      len = $urandom_range(0, 60);
      for (int i = 0; i < len; i++) begin
        if (t % 3 == 0)
          q_prod.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(60, 127))
                                                       : -int'($urandom_range(60, 128)));
        else
          q_prod.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_op($sformatf("rnd%0d", t), len, $urandom_range(0, 40),
             $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_prod_accumulator.md
Name: booth_prod_accumulator

Overview:
Downstream consumer of the 4-bit Booth array multiplier's signed 8-bit product stream. It accumulates a programmed number of products into a signed saturating accumulator, producing a dot-product or MAC result. The result is presented on a valid/ready output port. The multiplier stays combinational; this block provides the sequencing, handshake and result buffering.

Parameters:
PW, 8, signed product width (matches the multiplier's prod output).
AW, 16, signed accumulator and result width; AW >= PW is required.
LEN_W, 8, width of the product-count field.

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse: begin an accumulation; sampled only in IDLE.
len  input  LEN_W  number of products to accumulate; sampled with start.
prod_valid  input  1  upstream product present.
prod_ready  output  1  block accepts product this cycle.
prod  input  PW  signed product from the Booth array.
acc_valid  output  1  result available.
acc_ready  input  1  downstream accepts result.
acc_out  output  AW  signed accumulated result.
sat_flag  output  1  sticky: saturation occurred in the current operation.
busy  output  1  high in ACCUM and HOLD.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, acc=0, count=0, acc_valid=0, prod_ready=0, acc_out=0, sat_flag=0, busy=0.
- The reset sequence applies from any state: the current operation is discarded and no result is emitted.
- FSM states: IDLE, ACCUM, HOLD. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE, start=1, len!=0: acc<=0, sat_flag<=0, count<=len, next state ACCUM.
- IDLE, start=1, len==0: acc<=0, sat_flag<=0, next state HOLD. The result is 0.
- IDLE, start=0: remain in IDLE.
- ACCUM: prod_ready=1. A transfer occurs when prod_valid&&prod_ready.
  - On each transfer, acc <= sat(acc + sign_extend(prod)) and count <= count-1.
  - Transfer with count==1: next state HOLD.
  - No transfer: hold acc, count and state.
- HOLD: prod_ready=0, acc_valid=1, acc_out=acc. These values stay stable until acc_ready=1. On acc_valid&&acc_ready, next state IDLE and acc_valid=0 the following cycle.
- Latency: when the final product transfers in cycle N, acc_valid is high in cycle N+1 with the final sum.
- For len=0, acc_valid is high in the cycle after start.
- Throughput: one product per cycle in ACCUM.
- Saturation arithmetic: compute the sum at AW+1 bits.
  - Sum > 2^(AW-1)-1: clamp to 2^(AW-1)-1 and set sat_flag.
  - Sum < -2^(AW-1): clamp to -2^(AW-1) and set sat_flag.
  - Accumulation continues from the clamped value.
- sat_flag clears only on an accepted start or on reset. It is valid alongside acc_out.
- start outside IDLE is ignored with no side effects, including start in HOLD coincident with acc_ready. A new start is taken in IDLE on a later cycle.
- prod_valid outside ACCUM is ignored because prod_ready=0.
- len and prod are sampled only on their qualifying events. Changes at other times have no effect.
- count wrap: none. len up to 2^LEN_W-1 is supported, and count never decrements below 1 in ACCUM.

Test Plan:
1. Reset mid-ACCUM: start, len=4, two products, then pulse rst_n low -> all outputs 0, state IDLE. A subsequent start, len=1, prod=5 -> acc_out=5.
2. Basic dot product: start, len=3, products 15, -9, 21 on consecutive cycles -> acc_valid high the cycle after the third transfer, acc_out=27, sat_flag=0.
3. Upstream bubbles and downstream backpressure: len=4, products 64, -56, 8, -42 with prod_valid gaps, hold acc_ready=0 for 5 cycles -> acc_out=-26 stable throughout, acc_valid stays high, then drops the cycle after acc_ready=1.
4. Saturation with AW=12 override: len=40, prod=64 each -> acc_out=2047, sat_flag=1. Negative case: len=40, prod=-56 -> acc_out=-2048, sat_flag=1. The next start clears sat_flag to 0.
5. len=0 and ignored starts: start, len=0 -> acc_valid next cycle, acc_out=0. A start pulse in ACCUM or HOLD (len=7) does not change count, acc or state. A prod_valid pulse in IDLE is not consumed.
6. Back-to-back: handshake acc_ready in the same cycle as a new start pulse -> start ignored. start the following cycle, len=2, products 3, 4 -> acc_out=7.
